// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display readback block:
// segment patterns, anode select codes and the blank-run default.
package disp_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [3:0] AN_DIG0  = 4'b1110;
    localparam logic [3:0] AN_DIG1  = 4'b1101;
    localparam logic [3:0] AN_DIG2  = 4'b1011;
    localparam logic [3:0] AN_DIG3  = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    localparam int BLANK_MIN_DEFAULT = 4;

endpackage

// File: rtl/seg7_decode.sv
// Active-low seven-segment pattern to hex nibble lookup.
// hit is low when the pattern is not one of the sixteen hex glyphs.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [6:0] sseg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        unique case (sseg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_readback.sv
// Reconstructs the four displayed digits from a multiplexed seven-segment
// scan, reports completed frames, their binary value, and scan faults.
module display_readback
    import disp_pkg::*;
#(
    parameter int BLANK_MIN = BLANK_MIN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] dig,
    output logic        frame_done,
    output logic [13:0] value,
    output logic        bcd_error,
    output logic        seg_error,
    output logic        an_error,
    output logic        blanked
);

    localparam int CW = $clog2(BLANK_MIN + 1);

    logic [3:0]    seen;
    logic [3:0]    seen_next;
    logic [15:0]   dig_next;
    logic          hit;
    logic [3:0]    nibble;
    logic          sel_legal;
    logic [1:0]    sel_idx;
    logic          is_blank;
    logic          frame_full;
    logic          bcd_bad;
    logic [13:0]   bin;
    logic [CW-1:0] blank_cnt;
    logic [CW-1:0] blank_cnt_next;

    seg7_decode u_decode (
        .sseg   (sseg),
        .hit    (hit),
        .nibble (nibble)
    );

    always_comb begin
        sel_legal = 1'b1;
        sel_idx   = 2'd0;
        unique case (an)
            AN_DIG0: sel_idx = 2'd0;
            AN_DIG1: sel_idx = 2'd1;
            AN_DIG2: sel_idx = 2'd2;
            AN_DIG3: sel_idx = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    assign is_blank   = (an == AN_BLANK);
    assign frame_full = (seen == 4'hF);

    assign bcd_bad = (dig[3:0] > 4'd9) || (dig[7:4] > 4'd9) ||
                     (dig[11:8] > 4'd9) || (dig[15:12] > 4'd9);

    assign bin = {10'd0, dig[15:12]} * 14'd1000 +
                 {10'd0, dig[11:8]}  * 14'd100 +
                 {10'd0, dig[7:4]}   * 14'd10 +
                 {10'd0, dig[3:0]};

    // A completed frame is retired on this edge, so any capture arriving
    // now is the first digit of the next frame.
    always_comb begin
        seen_next = frame_full ? 4'b0000 : seen;
        dig_next  = dig;
        if (sel_legal && hit) begin
            dig_next[{sel_idx, 2'b00} +: 4] = nibble;
            seen_next[sel_idx]              = 1'b1;
        end else if (!is_blank) begin
            seen_next = 4'b0000;
        end
    end

    always_comb begin
        blank_cnt_next = '0;
        if (is_blank) begin
            if (blank_cnt == CW'(BLANK_MIN))
                blank_cnt_next = blank_cnt;
            else
                blank_cnt_next = blank_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig        <= '0;
            seen       <= '0;
            value      <= '0;
            blank_cnt  <= '0;
            frame_done <= 1'b0;
            bcd_error  <= 1'b0;
            seg_error  <= 1'b0;
            an_error   <= 1'b0;
            blanked    <= 1'b0;
        end else begin
            dig        <= dig_next;
            seen       <= seen_next;
            blank_cnt  <= blank_cnt_next;
            blanked    <= (blank_cnt_next == CW'(BLANK_MIN));
            seg_error  <= sel_legal && !hit;
            an_error   <= !sel_legal && !is_blank;
            frame_done <= frame_full;
            bcd_error  <= frame_full && bcd_bad;
            if (frame_full && !bcd_bad)
                value <= bin;
        end
    end

endmodule

// File: doc/display_readback.md
DISPLAY_READBACK -- requirements
Module: display_readback

Interface
REQ-001 Parameter BLANK_MIN, default 4, is the number of consecutive all-anodes-off cycles that declares the display blanked.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  system clock, same clock that drives the display scanner.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 an  input  4  anode selects, active-low, bit i selects digit i.
REQ-006 sseg  input  7  segment pattern, active-low, {g,f,e,d,c,b,a}.
REQ-007 dig  output  16  last captured nibbles, {dig3,dig2,dig1,dig0}.
REQ-008 frame_done  output  1  one-cycle pulse when all four digits have been captured since the last frame or abort.
REQ-009 value  output  14  binary value of the last valid BCD frame, saturated at 9999.
REQ-010 bcd_error  output  1  one-cycle pulse, coincident with frame_done, when any captured digit is greater than 9.
REQ-011 seg_error  output  1  one-cycle pulse when an unknown sseg pattern is seen under a legal select.
REQ-012 an_error  output  1  one-cycle pulse when an is not one-hot-low and not 4'b1111.
REQ-013 blanked  output  1  level; display is currently dark.

Function
REQ-014 All inputs SHALL be sampled at every rising clk edge; all outputs SHALL be registered.
REQ-015 Legal selects: 1110, 1101, 1011 and 0111 select digit 0 to digit 3. 1111 is a blank cycle. Any other value is illegal.
REQ-016 Pattern decode SHALL use the 16-entry active-low hex table:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, B=0000011
- C=1000110, D=0100001, E=0000110, F=0001110
REQ-017 On a legal select with a known pattern, the selected nibble of dig SHALL update at that edge, and seen[i] SHALL be set.
REQ-018 A repeated select of an already-seen digit SHALL overwrite the nibble without producing frame_done.
REQ-019 When seen becomes 4'b1111, the following happen on the next edge, so latency is 1 cycle after the fourth capture:
- frame_done pulses;
- seen clears;
- value is updated to d3*1000 + d2*100 + d1*10 + d0, only if all digits are 9 or less.
REQ-020 If any digit is greater than 9, value SHALL hold and bcd_error SHALL pulse with frame_done.
REQ-021 An unknown pattern under a legal select SHALL pulse seg_error, leave dig unchanged, and clear seen (frame abort).
REQ-022 An illegal an SHALL pulse an_error and clear seen, regardless of sseg.
REQ-023 Blank cycles SHALL NOT alter dig or seen.
REQ-024 A blank run counter increments on each 1111 cycle and saturates at BLANK_MIN.
REQ-025 blanked SHALL assert on the edge where the counter reaches BLANK_MIN.
REQ-026 The blank counter and blanked SHALL clear on the first legal or illegal non-1111 select.
REQ-027 The BCD-to-binary conversion SHALL be computed in 14-bit unsigned arithmetic; the maximum result is 9999, so there is no overflow.

Reset
REQ-028 reset SHALL dominate all other events in the same cycle.
REQ-029 On reset: dig=0, seen=0, value=0, blank counter=0, and frame_done, bcd_error, seg_error, an_error and blanked all 0.
REQ-030 A reset asserted mid-frame SHALL discard partial captures, so no frame_done follows.

Structure
REQ-031 The shared package disp_pkg SHALL hold:
- the 16 segment pattern constants;
- the four legal anode codes and the blank code;
- the default BLANK_MIN.
REQ-032 One combinational sub-module, seg7_decode, SHALL map sseg to {hit, nibble[3:0]}.
REQ-033 Frame tracking, blank detection and conversion SHALL be implemented in display_readback.

Verification
REQ-034 Scan digits 0,1,2,3 with 5,0,2,1 (0010010, 1000000, 0100100, 1111001) -> frame_done 1 cycle later, dig=16'h1205, value=1205.
REQ-035 Scan 1110 with 0001000 (A), then the other three digits with 0 -> frame_done and bcd_error both pulse, value holds its prior value.
REQ-036 Scan digits 0 and 1, then an=1100 -> an_error pulse, no frame_done; then four further legal captures -> frame_done.
REQ-037 Hold an=1111 for 3 cycles -> blanked=0; hold for 4 cycles -> blanked=1; next select 1110 -> blanked=0 and dig0 updated.
REQ-038 Assert reset after 3 of 4 digits, release it, then scan 1 digit -> no frame_done, and all outputs are 0 during reset.
REQ-039 Legal select with sseg=1111111 -> seg_error pulse, dig unchanged, seen cleared.
